// File: rtl/traffic_light_renderer.sv
// Traffic-light sprite renderer for the VGA path.
// Each accepted screen pixel is classified as outline, lit lamp, dim lamp or
// transparent. The result appears two cycles after the pixel is accepted.
// Lamp commands and blink enable are latched once per frame. A frame-counted
// blink phase is kept internally.
module traffic_light_renderer #(
    parameter int COORD_W      = 10,
    parameter int SPRITE_W     = 40,
    parameter int SPRITE_H     = 40,
    parameter int NUM_LAMPS    = 2,
    parameter int BORDER       = 2,
    parameter int LAMP_R       = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [COORD_W-1:0]   pix_x,
    input  logic [COORD_W-1:0]   pix_y,
    input  logic [COORD_W-1:0]   origin_x,
    input  logic [COORD_W-1:0]   origin_y,
    input  logic [NUM_LAMPS-1:0] lamp_on,
    input  logic                 blink_en,
    output logic                 out_valid,
    output logic                 out_draw,
    output logic [1:0]           out_color,
    output logic [1:0]           out_lamp
);

    // S holds a signed sprite-relative coordinate. D leaves headroom for
    // subtracting a lamp centre from it.
    localparam int S     = COORD_W + 1;
    localparam int D     = COORD_W + 2;
    localparam int PITCH = (SPRITE_H - 2 * BORDER) / (2 * NUM_LAMPS);
    localparam int CX    = SPRITE_W / 2;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic signed [S-1:0] SW_S     = S'(SPRITE_W);
    localparam logic signed [S-1:0] SH_S     = S'(SPRITE_H);
    localparam logic signed [S-1:0] BORD_S   = S'(BORDER);
    localparam logic signed [S-1:0] SW_IN_S  = S'(SPRITE_W - BORDER);
    localparam logic signed [S-1:0] SH_IN_S  = S'(SPRITE_H - BORDER);
    localparam logic [D-1:0]        CX_D     = D'(CX);
    localparam logic [2*D:0]        R2       = (2*D+1)'(LAMP_R * LAMP_R);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Per-frame latched controls and blink state.
    logic [NUM_LAMPS-1:0] lampOnLat_q, lampOnLat_d;
    logic                 blinkEnLat_q, blinkEnLat_d;
    logic [CNT_W-1:0]     frameCnt_q, frameCnt_d;
    logic                 blinkPhase_q, blinkPhase_d;

    // Stage 1 registers.
    logic                 v1_q, v1_d;
    logic                 inBox1_q, inBox1_d;
    logic                 border1_q, border1_d;
    logic signed [D-1:0]  dx1_q, dx1_d;
    logic signed [D-1:0]  dy1_q [NUM_LAMPS];
    logic signed [D-1:0]  dy1_d [NUM_LAMPS];
    logic [NUM_LAMPS-1:0] lit1_q, lit1_d;

    // Stage 2 registers.
    logic                 v2_q, v2_d;
    logic                 inBox2_q, inBox2_d;
    logic                 border2_q, border2_d;
    logic [NUM_LAMPS-1:0] hit2_q, hit2_d;
    logic [NUM_LAMPS-1:0] lit2_q, lit2_d;

    // Output registers.
    logic       outValid_q, outValid_d;
    logic       outDraw_q, outDraw_d;
    logic [1:0] outColor_q, outColor_d;
    logic [1:0] outLamp_q, outLamp_d;

    logic signed [S-1:0] sx, sy;

    // Frame latch and blink counter. A fresh enable of blinking restarts the
    // half-period in the visible phase.
    always_comb begin
        lampOnLat_d  = lampOnLat_q;
        blinkEnLat_d = blinkEnLat_q;
        frameCnt_d   = frameCnt_q;
        blinkPhase_d = blinkPhase_q;
        if (frame_start) begin
            lampOnLat_d  = lamp_on;
            blinkEnLat_d = blink_en;
            if (blink_en && !blinkEnLat_q) begin
                frameCnt_d   = '0;
                blinkPhase_d = 1'b1;
            end else if (frameCnt_q == CNT_LAST) begin
                frameCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                frameCnt_d = frameCnt_q + CNT_W'(1);
            end
        end
    end

    // Stage 1: sprite-relative coordinates, box and border tests, lamp offsets.
    // The lit mask is captured here, so a pixel uses the controls latched
    // when it was accepted.
    always_comb begin
        sx = $signed({1'b0, pix_x}) - $signed({1'b0, origin_x});
        sy = $signed({1'b0, pix_y}) - $signed({1'b0, origin_y});
        v1_d      = pix_valid;
        inBox1_d  = !sx[S-1] && (sx < SW_S) && !sy[S-1] && (sy < SH_S);
        border1_d = (sx < BORD_S) || (sx >= SW_IN_S) ||
                    (sy < BORD_S) || (sy >= SH_IN_S);
        dx1_d     = $signed({sx[S-1], sx}) - $signed(CX_D);
        for (int i = 0; i < NUM_LAMPS; i++) begin
            dy1_d[i]  = $signed({sy[S-1], sy}) -
                        $signed(D'(BORDER + (2 * i + 1) * PITCH));
            lit1_d[i] = lampOnLat_q[i] && (!blinkEnLat_q || blinkPhase_q);
        end
    end

    // Stage 2: circle membership test for every lamp, using full-width squares.
    always_comb begin
        logic [D-1:0]   magX, magY;
        logic [2*D-1:0] wideX, wideY;
        logic [2*D:0]   dist2;
        v2_d      = v1_q;
        inBox2_d  = inBox1_q;
        border2_d = border1_q;
        lit2_d    = lit1_q;
        hit2_d    = '0;
        magX      = dx1_q[D-1] ? D'(-dx1_q) : D'(dx1_q);
        wideX     = {{D{1'b0}}, magX};
        for (int i = 0; i < NUM_LAMPS; i++) begin
            magY      = dy1_q[i][D-1] ? D'(-dy1_q[i]) : D'(dy1_q[i]);
            wideY     = {{D{1'b0}}, magY};
            dist2     = {1'b0, wideX * wideX} + {1'b0, wideY * wideY};
            hit2_d[i] = (dist2 <= R2);
        end
    end

    // Output stage priority: outside the box, then outline, then the lowest
    // hit lamp, otherwise transparent. Bubbles produce all-zero outputs.
    always_comb begin
        outValid_d = v2_q;
        outDraw_d  = 1'b0;
        outColor_d = 2'd0;
        outLamp_d  = 2'd0;
        if (v2_q && inBox2_q) begin
            if (border2_q) begin
                outDraw_d = 1'b1;
            end else begin
                for (int i = NUM_LAMPS - 1; i >= 0; i--) begin
                    if (hit2_q[i]) begin
                        outDraw_d  = 1'b1;
                        outColor_d = lit2_q[i] ? 2'd1 : 2'd2;
                        outLamp_d  = 2'(i);
                    end
                end
            end
        end
    end

    // All state registers. Reset clears in-flight pixels and the latched
    // controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lampOnLat_q  <= '0;
            blinkEnLat_q <= 1'b0;
            frameCnt_q   <= '0;
            blinkPhase_q <= 1'b1;
            v1_q         <= 1'b0;
            inBox1_q     <= 1'b0;
            border1_q    <= 1'b0;
            dx1_q        <= '0;
            for (int i = 0; i < NUM_LAMPS; i++) dy1_q[i] <= '0;
            lit1_q       <= '0;
            v2_q         <= 1'b0;
            inBox2_q     <= 1'b0;
            border2_q    <= 1'b0;
            hit2_q       <= '0;
            lit2_q       <= '0;
            outValid_q   <= 1'b0;
            outDraw_q    <= 1'b0;
            outColor_q   <= 2'd0;
            outLamp_q    <= 2'd0;
        end else begin
            lampOnLat_q  <= lampOnLat_d;
            blinkEnLat_q <= blinkEnLat_d;
            frameCnt_q   <= frameCnt_d;
            blinkPhase_q <= blinkPhase_d;
            v1_q         <= v1_d;
            inBox1_q     <= inBox1_d;
            border1_q    <= border1_d;
            dx1_q        <= dx1_d;
            for (int i = 0; i < NUM_LAMPS; i++) dy1_q[i] <= dy1_d[i];
            lit1_q       <= lit1_d;
            v2_q         <= v2_d;
            inBox2_q     <= inBox2_d;
            border2_q    <= border2_d;
            hit2_q       <= hit2_d;
            lit2_q       <= lit2_d;
            outValid_q   <= outValid_d;
            outDraw_q    <= outDraw_d;
            outColor_q   <= outColor_d;
            outLamp_q    <= outLamp_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_draw  = outDraw_q;
    assign out_color = outColor_q;
    assign out_lamp  = outLamp_q;

endmodule

// File: tb/tb_traffic_light_renderer.sv
// Testbench for traffic_light_renderer.
// A reference model classifies pixels with integer geometry. It derives the
// blink phase from a count of frames since the last restart.
module tb_traffic_light_renderer;

    localparam int CW    = 10;
    localparam int SW    = 40;
    localparam int SH    = 40;
    localparam int NL    = 2;
    localparam int BORD  = 2;
    localparam int LR    = 8;
    localparam int BF    = 30;
    localparam int PITCH = (SH - 2 * BORD) / (2 * NL);
    localparam int CX    = SW / 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [CW-1:0] pix_x = '0;
    logic [CW-1:0] pix_y = '0;
    logic [CW-1:0] origin_x = '0;
    logic [CW-1:0] origin_y = '0;
    logic [NL-1:0] lamp_on = '0;
    logic          blink_en = 1'b0;
    logic          out_valid, out_draw;
    logic [1:0]    out_color, out_lamp;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {valid, draw, color, lamp}. Entry 2 is what
    // the DUT shows after the current edge.
    logic [5:0]    pipe [3];
    logic [NL-1:0] mLampOn;
    logic          mBlinkEn;
    int            mFrames;

    traffic_light_renderer #(
        .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH), .NUM_LAMPS(NL),
        .BORDER(BORD), .LAMP_R(LR), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .origin_x(origin_x), .origin_y(origin_y), .lamp_on(lamp_on),
        .blink_en(blink_en), .out_valid(out_valid), .out_draw(out_draw),
        .out_color(out_color), .out_lamp(out_lamp)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] refPixel(input int px, input int py,
                                            input int ox, input int oy,
                                            input logic [3:0] lit);
        int sx, sy, cy, d2;
        sx = px - ox;
        sy = py - oy;
        if (sx < 0 || sx >= SW || sy < 0 || sy >= SH) return 6'b10_00_00;
        if (sx < BORD || sx >= SW - BORD || sy < BORD || sy >= SH - BORD)
            return 6'b11_00_00;
        for (int i = 0; i < NL; i++) begin
            cy = BORD + (2 * i + 1) * PITCH;
            d2 = (sx - CX) * (sx - CX) + (sy - cy) * (sy - cy);
            if (d2 <= LR * LR) return {2'b11, (lit[i] ? 2'd1 : 2'd2), 2'(i)};
        end
        return 6'b10_00_00;
    endfunction

    task automatic modelEdge();
        logic [3:0] lit;
        logic       phase;
        logic [5:0] res;
        phase = ((mFrames / BF) % 2) == 0;
        lit = '0;
        for (int i = 0; i < NL; i++) lit[i] = mLampOn[i] && (!mBlinkEn || phase);
        res = pix_valid ? refPixel(int'(pix_x), int'(pix_y), int'(origin_x),
                                   int'(origin_y), lit) : 6'b0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = res;
        if (frame_start) begin
            if (blink_en && !mBlinkEn) mFrames = 0;
            else mFrames++;
            mLampOn  = lamp_on;
            mBlinkEn = blink_en;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expected);
        logic [5:0] observed;
        observed = {out_valid, out_draw, out_color, out_lamp};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed v/d/c/l=%b expected %b at %0t",
                   tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic fs, input logic pv,
                                 input int px, input int py, input string tag);
        @(negedge clk);
        frame_start = fs;
        pix_valid   = pv;
        pix_x       = CW'(px);
        pix_y       = CW'(py);
        @(posedge clk);
        modelEdge();
        #1 checkOutput(tag, pipe[2]);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset       = 1'b1;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        mLampOn  = '0;
        mBlinkEn = 1'b0;
        mFrames  = 0;
        checkOutput("reset_async", 6'b0);
        @(posedge clk);
        #1 checkOutput("reset_hold", 6'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        mLampOn  = '0;
        mBlinkEn = 1'b0;
        mFrames  = 0;
        applyReset();

        // Basic geometry with lamp0 commanded lit.
        origin_x = 10'd100;
        origin_y = 10'd50;
        lamp_on  = 2'b01;
        blink_en = 1'b0;
        applyStimulus(1, 0, 0, 0, "frame0");
        applyStimulus(0, 1, 120, 61, "lamp0_centre");
        applyStimulus(0, 1, 100, 50, "corner");
        applyStimulus(0, 1, 120, 70, "between_lamps");
        applyStimulus(0, 1, 99, 50, "left_of_box");
        applyStimulus(0, 1, 140, 50, "right_of_box");
        applyStimulus(0, 1, 120, 89, "bottom_border");
        applyStimulus(0, 1, 120, 79, "lamp1_dim");
        applyStimulus(0, 1, 128, 61, "lamp0_edge");
        applyStimulus(0, 1, 129, 61, "lamp0_outside");
        applyStimulus(0, 0, 0, 0, "flush");
        applyStimulus(0, 0, 0, 0, "flush");

        // Back-to-back pixels with one bubble.
        for (int k = 0; k < 8; k++)
            applyStimulus(0, (k != 3), 100 + k * 5, 61, "burst");
        applyStimulus(0, 0, 0, 0, "burst_flush");
        applyStimulus(0, 0, 0, 0, "burst_flush");

        // A mid-frame lamp change waits for the next frame_start.
        lamp_on = 2'b10;
        applyStimulus(0, 1, 120, 61, "midframe_lamp0");
        applyStimulus(0, 1, 120, 79, "midframe_lamp1");
        applyStimulus(1, 1, 120, 79, "fs_same_cycle");
        applyStimulus(0, 1, 120, 79, "newframe_lamp1");
        applyStimulus(0, 1, 120, 61, "newframe_lamp0");
        applyStimulus(0, 0, 0, 0, "flush");
        applyStimulus(0, 0, 0, 0, "flush");

        // Blinking through two half-periods, then disabled again.
        lamp_on  = 2'b01;
        blink_en = 1'b1;
        for (int f = 0; f < 2 * BF; f++) begin
            applyStimulus(1, 0, 0, 0, "blink_fs");
            applyStimulus(0, 1, 120, 61, "blink_px");
        end
        blink_en = 1'b0;
        applyStimulus(1, 0, 0, 0, "unblink_fs");
        applyStimulus(0, 1, 120, 61, "unblink_px");
        applyStimulus(0, 0, 0, 0, "flush");
        applyStimulus(0, 0, 0, 0, "flush");

        // Reset with two pixels in flight.
        applyStimulus(0, 1, 120, 61, "inflight0");
        applyStimulus(0, 1, 120, 79, "inflight1");
        applyReset();
        origin_x = 10'd100;
        origin_y = 10'd50;
        applyStimulus(0, 1, 120, 61, "post_reset_lamp0");
        applyStimulus(0, 0, 0, 0, "post_reset_flush");
        applyStimulus(0, 0, 0, 0, "post_reset_flush");

        // Randomised traffic including origins near the coordinate limits.
        for (int n = 0; n < 600; n++) begin
            int px, py;
            if ($urandom % 50 == 0) begin
                origin_x = CW'($urandom_range(0, 1023));
                origin_y = CW'($urandom_range(0, 1023));
            end
            if ($urandom % 5 == 0) lamp_on = NL'($urandom);
            if ($urandom % 7 == 0) blink_en = ($urandom % 3) != 0;
            if ($urandom % 4 == 0) begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end else begin
                px = int'(origin_x) + int'($urandom_range(0, 49)) - 5;
                py = int'(origin_y) + int'($urandom_range(0, 49)) - 5;
            end
            applyStimulus(($urandom % 6) == 0, ($urandom % 5) != 0,
                          px & 1023, py & 1023, "random");
        end
        applyStimulus(0, 0, 0, 0, "final_flush");
        applyStimulus(0, 0, 0, 0, "final_flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
